// File: rtl/d_e_pipe_reg_pkg.sv
// ============================================================================
// Module : d_e_pipe_reg_pkg
// Brief  : Shared opcode/NOP constants and stall/bubble action decode for the
//          D/E pipeline register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package d_e_pipe_reg_pkg;

    localparam logic [6:0]  OP_IMM        = 7'b0010011;
    localparam logic [6:0]  OP_LOAD       = 7'b0000011;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_BUBBLE = 2'd2
    } e_action_t;

    // Bubble dominates stall; a simultaneous request still resolves to bubble.
    function automatic e_action_t decode_action(input logic stall, input logic bubble);
        if (bubble)     return ACT_BUBBLE;
        else if (stall) return ACT_STALL;
        else            return ACT_LOAD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/d_e_pipe_reg_if.sv
// ============================================================================
// Module : d_e_pipe_reg_if
// Brief  : Decode-side inputs, hazard controls and execute-side outputs of the
//          D/E register. Perf counter signals exist only with HAZARD_PERF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface d_e_pipe_reg_if #(
    parameter int XLEN = 32
);
    logic            E_stall_i;
    logic            E_bubble_i;
    logic            D_valid_i;
    logic [XLEN-1:0] D_pc_i;
    logic [31:0]     D_instr_i;
    logic [6:0]      D_opcode_i;
    logic [4:0]      D_rd_i;
    logic [4:0]      D_rs1_i;
    logic [4:0]      D_rs2_i;
    logic [XLEN-1:0] D_imm_i;
    logic [XLEN-1:0] D_valA_i;
    logic [XLEN-1:0] D_valB_i;

    logic            E_valid_o;
    logic [XLEN-1:0] E_pc_o;
    logic [31:0]     E_instr_o;
    logic [6:0]      E_opcode_o;
    logic [4:0]      E_rd_o;
    logic [4:0]      E_rs1_o;
    logic [4:0]      E_rs2_o;
    logic [XLEN-1:0] E_imm_o;
    logic [XLEN-1:0] E_valA_o;
    logic [XLEN-1:0] E_valB_o;
    logic            ctl_err_o;
    logic            stall_timeout_o;
`ifdef HAZARD_PERF_EN
    logic [31:0]     perf_stall_cnt_o;
    logic [31:0]     perf_bubble_cnt_o;
    logic [31:0]     perf_issue_cnt_o;
`endif

    modport master (
        output E_stall_i, E_bubble_i, D_valid_i, D_pc_i, D_instr_i, D_opcode_i,
               D_rd_i, D_rs1_i, D_rs2_i, D_imm_i, D_valA_i, D_valB_i,
        input  E_valid_o, E_pc_o, E_instr_o, E_opcode_o, E_rd_o, E_rs1_o,
               E_rs2_o, E_imm_o, E_valA_o, E_valB_o, ctl_err_o, stall_timeout_o
`ifdef HAZARD_PERF_EN
        , input perf_stall_cnt_o, perf_bubble_cnt_o, perf_issue_cnt_o
`endif
    );

    modport slave (
        input  E_stall_i, E_bubble_i, D_valid_i, D_pc_i, D_instr_i, D_opcode_i,
               D_rd_i, D_rs1_i, D_rs2_i, D_imm_i, D_valA_i, D_valB_i,
        output E_valid_o, E_pc_o, E_instr_o, E_opcode_o, E_rd_o, E_rs1_o,
               E_rs2_o, E_imm_o, E_valA_o, E_valB_o, ctl_err_o, stall_timeout_o
`ifdef HAZARD_PERF_EN
        , output perf_stall_cnt_o, perf_bubble_cnt_o, perf_issue_cnt_o
`endif
    );

endinterface

`default_nettype wire

// File: rtl/d_e_pipe_reg_stall_watchdog.sv
// ============================================================================
// Module : stall_watchdog
// Brief  : Saturating consecutive-stall counter with a sticky timeout flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_watchdog #(
    parameter int MAX_STALL = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic stall_apply,
    output logic      timeout
);
    localparam int CW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // A stall seen with the counter already saturated is the (MAX_STALL+1)th.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (stall_apply) begin
            if (r_cnt == CW'(MAX_STALL)) begin
                r_timeout <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/d_e_pipe_reg.sv
// ============================================================================
// Module : d_e_pipe_reg
// Brief  : Decode-to-execute pipeline register with stall/bubble control,
//          conflict flag and stall watchdog. Optional HAZARD_PERF_EN macro adds
//          stall/bubble/issue performance counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          MAX_STALL = 15,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  wire logic       clk_i,
    input  wire logic       rst_n_i,
    d_e_pipe_reg_if.slave   bus
);
    e_action_t       w_action;
    logic            w_stall_apply;
    logic            w_conflict;
    logic            w_timeout;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [6:0]      r_opcode;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_vala;
    logic [XLEN-1:0] r_valb;
    logic            r_ctl_err;

    assign w_action      = decode_action(bus.E_stall_i, bus.E_bubble_i);
    assign w_stall_apply = (w_action == ACT_STALL);
    assign w_conflict    = bus.E_stall_i & bus.E_bubble_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_instr  <= NOP_INSTR;
            r_opcode <= OP_IMM;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_vala   <= '0;
            r_valb   <= '0;
        end else begin
            case (w_action)
                ACT_BUBBLE: begin
                    // pc is still captured so a bubble can be traced in debug.
                    r_valid  <= 1'b0;
                    r_pc     <= bus.D_pc_i;
                    r_instr  <= NOP_INSTR;
                    r_opcode <= OP_IMM;
                    r_rd     <= '0;
                    r_rs1    <= '0;
                    r_rs2    <= '0;
                    r_imm    <= '0;
                    r_vala   <= '0;
                    r_valb   <= '0;
                end
                ACT_LOAD: begin
                    // An invalid entry never names a destination register.
                    r_valid  <= bus.D_valid_i;
                    r_pc     <= bus.D_pc_i;
                    r_instr  <= bus.D_instr_i;
                    r_opcode <= bus.D_opcode_i;
                    r_rd     <= bus.D_valid_i ? bus.D_rd_i : 5'd0;
                    r_rs1    <= bus.D_rs1_i;
                    r_rs2    <= bus.D_rs2_i;
                    r_imm    <= bus.D_imm_i;
                    r_vala   <= bus.D_valA_i;
                    r_valb   <= bus.D_valB_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctl_err <= 1'b0;
        end else if (w_conflict) begin
            r_ctl_err <= 1'b1;
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .stall_apply (w_stall_apply),
        .timeout     (w_timeout)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_issue;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
            r_perf_issue  <= '0;
        end else begin
            if (w_action == ACT_STALL)                    r_perf_stall  <= r_perf_stall + 32'd1;
            if (w_action == ACT_BUBBLE)                   r_perf_bubble <= r_perf_bubble + 32'd1;
            if ((w_action == ACT_LOAD) && bus.D_valid_i)  r_perf_issue  <= r_perf_issue + 32'd1;
        end
    end

    assign bus.perf_stall_cnt_o  = r_perf_stall;
    assign bus.perf_bubble_cnt_o = r_perf_bubble;
    assign bus.perf_issue_cnt_o  = r_perf_issue;
`endif

    assign bus.E_valid_o       = r_valid;
    assign bus.E_pc_o          = r_pc;
    assign bus.E_instr_o       = r_instr;
    assign bus.E_opcode_o      = r_opcode;
    assign bus.E_rd_o          = r_rd;
    assign bus.E_rs1_o         = r_rs1;
    assign bus.E_rs2_o         = r_rs2;
    assign bus.E_imm_o         = r_imm;
    assign bus.E_valA_o        = r_vala;
    assign bus.E_valB_o        = r_valb;
    assign bus.ctl_err_o       = r_ctl_err;
    assign bus.stall_timeout_o = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_d_e_pipe_reg.sv
// ============================================================================
// Module : tb_d_e_pipe_reg
// Brief  : Table-driven bench with expected-result queue for d_e_pipe_reg.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_e_pipe_reg;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    d_e_pipe_reg_if #(.XLEN(32)) bus ();

    d_e_pipe_reg #(
        .XLEN      (32),
        .MAX_STALL (15),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall, bubble, valid;
        logic [31:0] pc, instr;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
        logic        e_bub;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, vala, valb;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    function automatic vec_t mk(input logic s, input logic b, input logic v,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic [4:0] erd,
                                input logic [31:0] eimm, input logic ebub);
        vec_t r;
        r.stall = s; r.bubble = b; r.valid = v; r.pc = pc; r.instr = instr;
        r.rd = rd; r.imm = imm; r.e_valid = ev; r.e_pc = epc; r.e_instr = einstr;
        r.e_rd = erd; r.e_imm = eimm; r.e_bub = ebub;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Secondary D fields are derived from pc so captured entries are self-describing.
    task automatic drive(input logic s, input logic b, input logic v,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic [31:0] imm);
        bus.E_stall_i  = s;
        bus.E_bubble_i = b;
        bus.D_valid_i  = v;
        bus.D_pc_i     = pc;
        bus.D_instr_i  = instr;
        bus.D_opcode_i = instr[6:0];
        bus.D_rd_i     = rd;
        bus.D_rs1_i    = pc[6:2];
        bus.D_rs2_i    = pc[11:7];
        bus.D_imm_i    = imm;
        bus.D_valA_i   = pc ^ 32'hA5A5_0000;
        bus.D_valB_i   = ~pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_nop(input string tag);
        check({tag, "_valid"}, 32'(bus.E_valid_o), 32'd0);
        check({tag, "_instr"}, bus.E_instr_o, 32'h0000_0013);
        check({tag, "_opcode"}, 32'(bus.E_opcode_o), 32'h13);
        check({tag, "_rd"}, 32'(bus.E_rd_o), 32'd0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEE0, 32'h0010_0093, 5'd1, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_nop("reset");
        check("reset_pc", bus.E_pc_o, 32'd0);
        check("reset_ctl_err", 32'(bus.ctl_err_o), 32'd0);
        check("reset_timeout", 32'(bus.stall_timeout_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = mk(0,0,1, 32'h100, 32'h0050_0293, 5'd5,  32'h5, 1, 32'h100, 32'h0050_0293, 5'd5,  32'h5, 0);
        vecs[1] = mk(1,0,1, 32'h200, 32'h00A0_0313, 5'd6,  32'hA, 1, 32'h100, 32'h0050_0293, 5'd5,  32'h5, 0);
        vecs[2] = mk(0,1,1, 32'h204, 32'h00B0_0393, 5'd7,  32'hB, 0, 32'h204, 32'h0000_0013, 5'd0,  32'h0, 1);
        vecs[3] = mk(0,0,1, 32'h208, 32'h0070_0393, 5'd7,  32'h7, 1, 32'h208, 32'h0070_0393, 5'd7,  32'h7, 0);
        vecs[4] = mk(0,0,0, 32'h20C, 32'h0080_0413, 5'd8,  32'h8, 0, 32'h20C, 32'h0080_0413, 5'd0,  32'h8, 0);
        vecs[5] = mk(0,0,1, 32'h210, 32'h0000_A503, 5'd10, 32'h0, 1, 32'h210, 32'h0000_A503, 5'd10, 32'h0, 0);
        vecs[6] = mk(1,0,1, 32'h214, 32'h00B0_0593, 5'd11, 32'hB, 1, 32'h210, 32'h0000_A503, 5'd10, 32'h0, 0);
        vecs[7] = mk(1,0,0, 32'h218, 32'h0000_0000, 5'd12, 32'h0, 1, 32'h210, 32'h0000_A503, 5'd10, 32'h0, 0);
        vecs[8] = mk(0,0,1, 32'h21C, 32'h00C0_0613, 5'd12, 32'hC, 1, 32'h21C, 32'h00C0_0613, 5'd12, 32'hC, 0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].stall, vecs[i].bubble, vecs[i].valid, vecs[i].pc,
                  vecs[i].instr, vecs[i].rd, vecs[i].imm);
            e.valid  = vecs[i].e_valid;
            e.pc     = vecs[i].e_pc;
            e.instr  = vecs[i].e_instr;
            e.opcode = vecs[i].e_instr[6:0];
            e.rd     = vecs[i].e_rd;
            e.imm    = vecs[i].e_imm;
            e.rs1    = vecs[i].e_bub ? 5'd0  : vecs[i].e_pc[6:2];
            e.rs2    = vecs[i].e_bub ? 5'd0  : vecs[i].e_pc[11:7];
            e.vala   = vecs[i].e_bub ? 32'd0 : (vecs[i].e_pc ^ 32'hA5A5_0000);
            e.valb   = vecs[i].e_bub ? 32'd0 : ~vecs[i].e_pc;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            check($sformatf("v%0d_valid", i),  32'(bus.E_valid_o),  32'(e.valid));
            check($sformatf("v%0d_pc", i),     bus.E_pc_o,          e.pc);
            check($sformatf("v%0d_instr", i),  bus.E_instr_o,       e.instr);
            check($sformatf("v%0d_opcode", i), 32'(bus.E_opcode_o), 32'(e.opcode));
            check($sformatf("v%0d_rd", i),     32'(bus.E_rd_o),     32'(e.rd));
            check($sformatf("v%0d_rs1", i),    32'(bus.E_rs1_o),    32'(e.rs1));
            check($sformatf("v%0d_rs2", i),    32'(bus.E_rs2_o),    32'(e.rs2));
            check($sformatf("v%0d_imm", i),    bus.E_imm_o,         e.imm);
            check($sformatf("v%0d_valA", i),   bus.E_valA_o,        e.vala);
            check($sformatf("v%0d_valB", i),   bus.E_valB_o,        e.valb);
        end
        check("table_ctl_err", 32'(bus.ctl_err_o), 32'd0);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check_nop("async_reset");
        check("async_reset_pc", bus.E_pc_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall and bubble together
        drive(1'b1, 1'b1, 1'b1, 32'h300, 32'h0010_0093, 5'd1, 32'h1);
        step();
        check_nop("conflict");
        check("conflict_pc", bus.E_pc_o, 32'h300);
        check("conflict_ctl_err", 32'(bus.ctl_err_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h400 + 32'(i * 4), 32'h0010_0093, 5'd1, 32'h1);
            step();
        end
        check("conflict_sticky", 32'(bus.ctl_err_o), 32'd1);
        check("conflict_after_load_rd", 32'(bus.E_rd_o), 32'd1);
        do_reset();
        check("conflict_cleared", 32'(bus.ctl_err_o), 32'd0);

        // Watchdog: 15 stalls tolerated, 16th fires
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h500, 32'h0010_0093, 5'd1, 32'h1);
            step();
        end
        check("wd_15_stalls", 32'(bus.stall_timeout_o), 32'd0);
        step();
        check("wd_16th_stall", 32'(bus.stall_timeout_o), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h504, 32'h0010_0093, 5'd1, 32'h1);
        step();
        check("wd_sticky", 32'(bus.stall_timeout_o), 32'd1);
        do_reset();
        check("wd_reset", 32'(bus.stall_timeout_o), 32'd0);

        // Broken stall runs never fire
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 15; i++) begin
                drive(1'b1, 1'b0, 1'b1, 32'h600, 32'h0010_0093, 5'd1, 32'h1);
                step();
            end
            drive(1'b0, 1'b0, 1'b1, 32'h604, 32'h0010_0093, 5'd1, 32'h1);
            step();
        end
        check("wd_broken_runs", 32'(bus.stall_timeout_o), 32'd0);

        // Stall run interrupted by reset restarts the count
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h700, 32'h0010_0093, 5'd1, 32'h1);
            step();
        end
        do_reset();
        for (int i = 0; i < 15; i++) step();
        check("wd_reset_mid_stall", 32'(bus.stall_timeout_o), 32'd0);
        do_reset();

`ifdef HAZARD_PERF_EN
        check("perf_reset_stall", bus.perf_stall_cnt_o, 32'd0);
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 32'h800, 32'h13, 5'd0, 32'h0); step(); end
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 1'b1, 32'h800, 32'h13, 5'd0, 32'h0); step(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b0, 1'b1, 32'h800, 32'h13, 5'd0, 32'h0); step(); end
        check("perf_stall", bus.perf_stall_cnt_o, 32'd3);
        check("perf_bubble", bus.perf_bubble_cnt_o, 32'd2);
        check("perf_issue", bus.perf_issue_cnt_o, 32'd4);
        drive(1'b1, 1'b1, 1'b1, 32'h800, 32'h13, 5'd0, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 32'h800, 32'h13, 5'd0, 32'h0); step();
        check("perf_conflict_stall", bus.perf_stall_cnt_o, 32'd3);
        check("perf_conflict_bubble", bus.perf_bubble_cnt_o, 32'd3);
        check("perf_invalid_issue", bus.perf_issue_cnt_o, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/d_e_pipe_reg.md
Name: d_e_pipe_reg

Overview:
- Decode-to-execute pipeline register. It is the consumer of the hazard controller's D/E stall and bubble outputs.
- Each cycle it captures the decoded instruction bundle, holds it on stall, or replaces it with a canonical NOP on bubble.
- Tracks a valid bit, flags illegal stall+bubble combinations, and watches for runaway stalls.
- Sits between the decode and execute stages; its E-stage outputs feed execute, forwarding and the hazard controller.

Parameters:
- XLEN, 32, width of pc/imm/operand fields.
- MAX_STALL, 15, consecutive stall cycles tolerated before timeout flag.
- NOP_INSTR, 32'h0000_0013, encoding loaded on bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- E_stall_i  in  1  hold E register contents.
- E_bubble_i  in  1  load NOP into E register.
- D_valid_i  in  1  decode stage holds a real instruction.
- D_pc_i  in  XLEN  decode pc.
- D_instr_i  in  32  decode instruction word.
- D_opcode_i  in  7  decoded opcode.
- D_rd_i / D_rs1_i / D_rs2_i  in  5 each  register indices.
- D_imm_i  in  XLEN  decoded immediate.
- D_valA_i / D_valB_i  in  XLEN each  read operands after forwarding.
- E_valid_o  out  1  execute stage holds a real instruction.
- E_pc_o, E_instr_o, E_opcode_o, E_rd_o, E_rs1_o, E_rs2_o, E_imm_o, E_valA_o, E_valB_o  out  matching widths  registered copies.
- ctl_err_o  out  1  sticky: stall and bubble asserted together.
- stall_timeout_o  out  1  sticky: stall held longer than MAX_STALL cycles.

Behaviour:
- Reset (async on rst_n_i low, released synchronously):
  - E_valid_o=0, E_instr_o=NOP_INSTR, E_opcode_o=`OP_IMM (7'b0010011).
  - All other data outputs 0; ctl_err_o=0, stall_timeout_o=0; stall counter=0.
- Per rising edge, priority bubble > stall > load:
  - Bubble: E_valid_o<=0, E_instr_o<=NOP_INSTR, E_opcode_o<=`OP_IMM. rd/rs1/rs2<=0, imm/valA/valB<=0. E_pc_o<=D_pc_i (kept for debug).
  - Stall only: all E outputs hold.
  - Neither: all E outputs <= D inputs; E_valid_o<=D_valid_i.
- Stall+bubble in the same cycle: the bubble is applied and ctl_err_o is set. It stays set until reset.
- Latency: exactly 1 cycle from D inputs to E outputs on a load.
- NOP invariant: an invalid E entry always carries rd=0, so downstream never writes a register and never matches load-use against it.
- Stall counter (4 bits for the default; width $clog2(MAX_STALL+1)):
  - Increments on each cycle with E_stall_i=1 and E_bubble_i=0.
  - Clears on any non-stall cycle.
  - Saturates at MAX_STALL. stall_timeout_o is set when a stall arrives with the counter already at MAX_STALL, i.e. on the (MAX_STALL+1)th consecutive stall; sticky until reset.
- Reset mid-stall: all state returns to reset values immediately and the counter clears.
- D_valid_i=0 loaded without a bubble: data fields still captured; E_valid_o=0 and rd forced to 0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds three 32-bit wrapping counters, reset 0, each exposed as an output:
  - perf_stall_cnt_o: cycles with stall applied.
  - perf_bubble_cnt_o: cycles with bubble applied.
  - perf_issue_cnt_o: cycles loading with D_valid_i=1.
- A stall+bubble cycle counts as a bubble only.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared define.v holds `OP_IMM, `OP_LOAD and the NOP_INSTR constant value.
- One natural sub-module: stall_watchdog (counter plus sticky timeout flag), reusable for the F/D registers.

Test Plan:
- Reset: rst_n_i low mid-cycle -> E_valid_o=0, E_instr_o=32'h13, E_rd_o=0 asynchronously; ctl_err_o=0.
- Load: D_valid_i=1, D_pc_i=32'h100, D_rd_i=5, no stall/bubble -> next edge E_pc_o=32'h100, E_rd_o=5, E_valid_o=1.
- Load-use: E_stall_i=1 for 1 cycle with D inputs changing -> E outputs unchanged. Then E_bubble_i=1 -> E_valid_o=0, E_rd_o=0, E_instr_o=32'h13.
- Conflict: E_stall_i=1 and E_bubble_i=1 together -> bubble applied, ctl_err_o=1 and still 1 after 10 clean cycles.
- Watchdog: 15 consecutive stalls -> stall_timeout_o=0; 16th stall -> stall_timeout_o=1. A fresh sequence of 15 stalls broken by one load cycle -> never fires.
- HAZARD_PERF_EN: 3 stalls, 2 bubbles, 4 valid loads -> counters read 3/2/4. Force perf_issue_cnt_o to 32'hFFFF_FFFF plus one valid load -> wraps to 0.
